// File: rtl/seg7_pkg.sv
// Shared types and the active-low hex segment table for the 7-segment scan driver.
package seg7_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG7_OFF = 7'h7F;

    // Codes are {g,f,e,d,c,b,a}, low = segment lit.
    localparam seg7_t SEG7_HEX_LUT [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low segment code lookup.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output seg7_t      seg_o
);

    assign seg_o = SEG7_HEX_LUT[nibble_i];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with guard time and frame-aligned updates.
// Optional leading-zero suppression is enabled by defining SEG7_LZ_SUPPRESS_EN.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int SLOT_CYCLES    = 50000,
    parameter int GUARD_CYCLES   = 16,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    load,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick,
    output logic                    upd_pending
);

    localparam int CW = $clog2(SLOT_CYCLES);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DW = 4 * NUM_DIGITS;

    localparam seg7_t                 SEG_DARK = (SEG_ACTIVE_LOW != 0) ? SEG7_OFF : 7'h00;
    localparam logic                  DP_DARK  = (SEG_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = (AN_ACTIVE_LOW != 0) ? '1 : '0;

    logic [CW-1:0]         slot_cnt_q, slot_cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DW-1:0]         pend_data_q, pend_data_d, act_data_q, act_data_d;
    logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
    logic [NUM_DIGITS-1:0] pend_blank_q, pend_blank_d, act_blank_q, act_blank_d;
    logic                  upd_pending_q, upd_pending_d;
    logic                  frame_tick_q, frame_tick_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    seg7_t                 seg_q, seg_d;
    logic                  dp_q, dp_d;

    logic                  slotLast, idxLast, boundary;
    logic [3:0]            curNibble;
    logic                  curDp, curDark;
    logic [NUM_DIGITS-1:0] anOneHot;
    seg7_t                 decoded;

    always_comb begin
        slotLast   = (slot_cnt_q == CW'(SLOT_CYCLES - 1));
        idxLast    = (idx_q == IW'(NUM_DIGITS - 1));
        boundary   = slotLast && idxLast;
        slot_cnt_d = slotLast ? '0 : slot_cnt_q + CW'(1);
        idx_d      = idx_q;
        if (slotLast) begin
            idx_d = idxLast ? '0 : idx_q + IW'(1);
        end
    end

    // Active data only changes on the frame boundary so a scan never mixes two values.
    always_comb begin
        pend_data_d   = pend_data_q;
        pend_dp_d     = pend_dp_q;
        pend_blank_d  = pend_blank_q;
        act_data_d    = act_data_q;
        act_dp_d      = act_dp_q;
        act_blank_d   = act_blank_q;
        upd_pending_d = upd_pending_q;
        if (load) begin
            pend_data_d  = data_in;
            pend_dp_d    = dp_in;
            pend_blank_d = blank_in;
        end
        if (boundary) begin
            upd_pending_d = 1'b0;
            if (load) begin
                act_data_d  = data_in;
                act_dp_d    = dp_in;
                act_blank_d = blank_in;
            end else if (upd_pending_q) begin
                act_data_d  = pend_data_q;
                act_dp_d    = pend_dp_q;
                act_blank_d = pend_blank_q;
            end
        end else if (load) begin
            upd_pending_d = 1'b1;
        end
    end

`ifdef SEG7_LZ_SUPPRESS_EN
    int keepTop;
`endif

    always_comb begin
        curNibble = '0;
        curDp     = 1'b0;
        curDark   = 1'b0;
        anOneHot  = '0;
`ifdef SEG7_LZ_SUPPRESS_EN
        // Highest digit that must stay visible: a nonzero nibble or a lit decimal point.
        keepTop = 0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if ((act_data_q[4*k +: 4] != 4'd0) || act_dp_q[k]) begin
                keepTop = k;
            end
        end
`endif
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                curNibble   = act_data_q[4*k +: 4];
                curDp       = act_dp_q[k];
                curDark     = act_blank_q[k];
                anOneHot[k] = 1'b1;
`ifdef SEG7_LZ_SUPPRESS_EN
                if (k > keepTop) begin
                    curDark = 1'b1;
                end
`endif
            end
        end
    end

    seg7_hex_decode uDecode (
        .nibble_i (curNibble),
        .seg_o    (decoded)
    );

    always_comb begin
        an_d         = AN_OFF;
        seg_d        = SEG_DARK;
        dp_d         = DP_DARK;
        frame_tick_d = boundary;
        if (slot_cnt_q >= CW'(GUARD_CYCLES)) begin
            an_d = (AN_ACTIVE_LOW != 0) ? ~anOneHot : anOneHot;
            if (!curDark) begin
                seg_d = (SEG_ACTIVE_LOW != 0) ? decoded : ~decoded;
                dp_d  = curDp ? ~DP_DARK : DP_DARK;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt_q    <= '0;
            idx_q         <= '0;
            pend_data_q   <= '0;
            pend_dp_q     <= '0;
            pend_blank_q  <= '0;
            act_data_q    <= '0;
            act_dp_q      <= '0;
            act_blank_q   <= '0;
            upd_pending_q <= 1'b0;
            frame_tick_q  <= 1'b0;
            an_q          <= AN_OFF;
            seg_q         <= SEG_DARK;
            dp_q          <= DP_DARK;
        end else begin
            slot_cnt_q    <= slot_cnt_d;
            idx_q         <= idx_d;
            pend_data_q   <= pend_data_d;
            pend_dp_q     <= pend_dp_d;
            pend_blank_q  <= pend_blank_d;
            act_data_q    <= act_data_d;
            act_dp_q      <= act_dp_d;
            act_blank_q   <= act_blank_d;
            upd_pending_q <= upd_pending_d;
            frame_tick_q  <= frame_tick_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
        end
    end

    assign seg         = seg_q;
    assign dp          = dp_q;
    assign an          = an_q;
    assign frame_tick  = frame_tick_q;
    assign upd_pending = upd_pending_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: vector table, corner sequences and random loads vs. a frame model.
module tb_seg7_scan_driver;

    localparam int ND    = 4;
    localparam int SC    = 8;
    localparam int GC    = 2;
    localparam int FRAME = ND * SC;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic        load;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_tick;
    logic        upd_pending;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .NUM_DIGITS     (ND),
        .SLOT_CYCLES    (SC),
        .GUARD_CYCLES   (GC),
        .SEG_ACTIVE_LOW (1),
        .AN_ACTIVE_LOW  (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_in     (data_in),
        .dp_in       (dp_in),
        .blank_in    (blank_in),
        .load        (load),
        .seg         (seg),
        .dp          (dp),
        .an          (an),
        .frame_tick  (frame_tick),
        .upd_pending (upd_pending)
    );

    logic [6:0] hexCode [16];

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  dpv;
        logic [3:0]  blank;
        logic [27:0] segExp;
        logic [3:0]  dpExp;
    } vec_t;

    vec_t vecs [5];

    // Reference model: time since reset plus the shown and queued display words.
    int          mt;
    int          lastT;
    logic [15:0] mActData, mPendData;
    logic [3:0]  mActDp, mPendDp, mActBlank, mPendBlank;
    bit          mUpd;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at t=%0t got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] d, input logic [3:0] p,
                                 input logic [3:0] b, input logic l);
        data_in  = d;
        dp_in    = p;
        blank_in = b;
        load     = l;
    endtask

    task automatic modelReset();
        mt = 0;
        lastT = 0;
        mActData = '0; mPendData = '0;
        mActDp = '0; mPendDp = '0;
        mActBlank = '0; mPendBlank = '0;
        mUpd = 1'b0;
    endtask

    function automatic bit digitShown(input int d);
`ifdef SEG7_LZ_SUPPRESS_EN
        int top;
        top = 0;
        for (int k = 0; k < ND; k++) begin
            if (mActData[4*k +: 4] != 4'd0 || mActDp[k]) top = k;
        end
        if (d > top) return 1'b0;
`endif
        return !mActBlank[d];
    endfunction

    // One clock: predict outputs from the pre-edge model, advance the model, compare at negedge.
    task automatic step();
        int         slot, dig;
        bit         bnd;
        logic [3:0] eAn;
        logic [6:0] eSeg;
        logic       eDp;
        slot = mt % SC;
        dig  = (mt / SC) % ND;
        bnd  = (mt % FRAME) == FRAME - 1;
        eAn  = 4'hF;
        eSeg = 7'h7F;
        eDp  = 1'b1;
        if (slot >= GC) begin
            eAn = ~(4'b0001 << dig);
            if (digitShown(dig)) begin
                eSeg = hexCode[mActData[4*dig +: 4]];
                eDp  = ~mActDp[dig];
            end
        end
        if (bnd) begin
            if (load) begin
                mActData = data_in; mActDp = dp_in; mActBlank = blank_in;
            end else if (mUpd) begin
                mActData = mPendData; mActDp = mPendDp; mActBlank = mPendBlank;
            end
            mUpd = 1'b0;
        end else if (load) begin
            mPendData = data_in; mPendDp = dp_in; mPendBlank = blank_in;
            mUpd = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        lastT = mt;
        mt++;
        checkOutput("an", 32'(an), 32'(eAn));
        checkOutput("seg", 32'(seg), 32'(eSeg));
        checkOutput("dp", 32'(dp), 32'(eDp));
        checkOutput("frame_tick", 32'(frame_tick), 32'(bnd));
        checkOutput("upd_pending", 32'(upd_pending), 32'(mUpd));
    endtask

    task automatic runToFrameEnd();
        for (int i = 0; i < FRAME && (lastT % FRAME) != FRAME - 1; i++) step();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int ticks;
        bit sawA;

        hexCode = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        vecs[0] = '{16'h1234, 4'h0, 4'h0,
                    {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 4'b1111};
        vecs[1] = '{16'h5555, 4'h0, 4'h0, {4{7'b0010010}}, 4'b1111};
        vecs[2] = '{16'hC0DE, 4'h0, 4'h0,
                    {7'b1000110, 7'b1000000, 7'b0100001, 7'b0000110}, 4'b1111};
        vecs[3] = '{16'h1234, 4'b0001, 4'b0100,
                    {7'b1111001, 7'h7F, 7'b0110000, 7'b0011001}, 4'b1110};
        vecs[4] = '{16'h6789, 4'b1010, 4'b1001,
                    {7'h7F, 7'b1111000, 7'b0000000, 7'h7F}, 4'b1101};

        rst_n = 1'b0;
        applyStimulus(16'h0, 4'h0, 4'h0, 1'b0);
        modelReset();
        repeat (3) @(negedge clk);
        checkOutput("rst_an", 32'(an), 32'hF);
        checkOutput("rst_seg", 32'(seg), 32'h7F);
        checkOutput("rst_dp", 32'(dp), 32'h1);
        checkOutput("rst_upd", 32'(upd_pending), 32'h0);
        checkOutput("rst_tick", 32'(frame_tick), 32'h0);

        rst_n = 1'b1;
        step();
        step();
        checkOutput("guard_an", 32'(an), 32'hF);
        step();
        checkOutput("first_anode", 32'(an), 32'hE);

        // Vector table: load, wait for the frame boundary, then check every digit slot.
        for (int v = 0; v < 5; v++) begin
            applyStimulus(vecs[v].data, vecs[v].dpv, vecs[v].blank, 1'b1);
            step();
            applyStimulus(vecs[v].data, vecs[v].dpv, vecs[v].blank, 1'b0);
            runToFrameEnd();
            for (int c = 0; c < FRAME; c++) begin
                step();
                if ((lastT % SC) == GC) begin
                    int d;
                    d = (lastT / SC) % ND;
                    checkOutput($sformatf("vec%0d_seg_d%0d", v, d), 32'(seg), 32'(vecs[v].segExp[7*d +: 7]));
                    checkOutput($sformatf("vec%0d_dp_d%0d", v, d), 32'(dp), 32'(vecs[v].dpExp[d]));
                end
            end
        end

        // Two loads inside one frame: only the last one is ever shown.
        runToFrameEnd();
        applyStimulus(16'hAAAA, 4'h0, 4'h0, 1'b1);
        step();
        applyStimulus(16'hAAAA, 4'h0, 4'h0, 1'b0);
        repeat (4) step();
        applyStimulus(16'h5555, 4'h0, 4'h0, 1'b1);
        step();
        applyStimulus(16'h5555, 4'h0, 4'h0, 1'b0);
        checkOutput("overwrite_pending", 32'(upd_pending), 32'h1);
        ticks = 0;
        sawA  = 1'b0;
        for (int c = 0; c < 2 * FRAME; c++) begin
            step();
            if (frame_tick) ticks++;
            if (an != 4'hF && seg == hexCode[10]) sawA = 1'b1;
        end
        checkOutput("tick_count", 32'(ticks), 32'd2);
        checkOutput("never_A", 32'(sawA), 32'd0);

        // Load exactly on the boundary cycle goes straight to the display.
        for (int i = 0; i < FRAME && (mt % FRAME) != FRAME - 1; i++) step();
        applyStimulus(16'h0009, 4'h0, 4'h0, 1'b1);
        step();
        applyStimulus(16'h0009, 4'h0, 4'h0, 1'b0);
        checkOutput("bnd_load_upd", 32'(upd_pending), 32'h0);
        for (int i = 0; i < SC && (lastT % FRAME) != GC; i++) step();
        checkOutput("bnd_load_seg", 32'(seg), 32'(7'b0010000));

        for (int i = 0; i < 400; i++) begin
            applyStimulus(16'($urandom), 4'($urandom), 4'($urandom), ($urandom_range(0, 3) == 0));
            step();
        end
        applyStimulus(16'h0, 4'h0, 4'h0, 1'b0);

`ifdef SEG7_LZ_SUPPRESS_EN
        applyStimulus(16'h0070, 4'h0, 4'h0, 1'b1);
        step();
        applyStimulus(16'h0070, 4'h0, 4'h0, 1'b0);
        runToFrameEnd();
        for (int c = 0; c < FRAME; c++) begin
            step();
            if ((lastT % SC) == GC) begin
                int d;
                logic [27:0] lzExp;
                lzExp = {7'h7F, 7'h7F, 7'b1111000, 7'b1000000};
                d = (lastT / SC) % ND;
                checkOutput($sformatf("lz_seg_d%0d", d), 32'(seg), 32'(lzExp[7*d +: 7]));
            end
        end
`endif

        // Asynchronous reset in the middle of a lit slot with a load in flight.
        for (int i = 0; i < SC && (lastT % SC) != 4; i++) step();
        applyStimulus(16'hBEEF, 4'hF, 4'h0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_an", 32'(an), 32'hF);
        checkOutput("midrst_seg", 32'(seg), 32'h7F);
        checkOutput("midrst_dp", 32'(dp), 32'h1);
        checkOutput("midrst_upd", 32'(upd_pending), 32'h0);
        modelReset();
        applyStimulus(16'h0, 4'h0, 4'h0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step();
        checkOutput("rerst_first_anode", 32'(an), 32'hE);
        checkOutput("rerst_seg", 32'(seg), 32'(7'b1000000));
        repeat (FRAME) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
